// File: rtl/gemm_pkg.sv
// Shared state type and sizing helpers for the GEMM operand skew feeder.
package gemm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } feed_state_t;

    localparam int unsigned LANE_W = 32;

    function automatic int unsigned beat_cnt_w(input int unsigned max_k);
        return $clog2(max_k + 1);
    endfunction

endpackage

// File: rtl/gemm_skew_feeder_if.sv
// Upstream beat handshake plus skewed per-lane outputs toward the array rows.
interface gemm_skew_feeder_if #(
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_LANES      = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic [C_LANES*C_DATA_WIDTH-1:0] in_data;
    logic                            in_last;
    logic [C_LANES*C_DATA_WIDTH-1:0] out_data;
    logic [C_LANES-1:0]              out_valid;
    logic [C_LANES-1:0]              out_last;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/gemm_skew_lane.sv
// Fixed-length delay line carrying one lane's data/valid/last; latency LEN cycles,
// shifts every cycle with no backpressure.
module gemm_skew_lane #(
    parameter int unsigned LEN = 1,
    parameter int unsigned W   = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last
);
    localparam int unsigned WW = W + 2;

    logic [WW-1:0]          in_word;
    logic [LEN-1:0][WW-1:0] sr_q;

    assign in_word = {in_valid, in_last, in_data};

    if (LEN == 1) begin : g_one
        always_ff @(posedge clock) begin
            if (reset) sr_q <= '0;
            else       sr_q[0] <= in_word;
        end
    end else begin : g_many
        always_ff @(posedge clock) begin
            if (reset) sr_q <= '0;
            else       sr_q <= {sr_q[LEN-2:0], in_word};
        end
    end

    assign out_valid = sr_q[LEN-1][WW-1];
    assign out_last  = sr_q[LEN-1][WW-2];
    assign out_data  = sr_q[LEN-1][W-1:0];
endmodule

// File: rtl/gemm_skew_feeder.sv
// Feeds operand-A beats into the array with lane i delayed i+1 cycles; in_ready drops
// for C_LANES-1 cycles after each tile's last beat so the skew drains.
module gemm_skew_feeder
    import gemm_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = LANE_W,
    parameter int unsigned C_LANES      = 4,
    parameter int unsigned C_MAX_K      = 256
) (
    input  logic                           clock,
    input  logic                           reset,
    gemm_skew_feeder_if.slave              feed,
    output logic                           tile_done,
    output logic [$clog2(C_MAX_K+1)-1:0]   tile_beats,
    output logic                           overflow
);
    localparam int unsigned CW = beat_cnt_w(C_MAX_K);
    localparam int unsigned DW = (C_LANES > 1) ? $clog2(C_LANES) : 1;

    feed_state_t             state_q, state_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [CW-1:0]           beat_q, beat_d, beats_q, beats_d, beat_inc;
    logic                    ovf_q, ovf_d;
    logic                    accept, last_accept, at_max;
    logic [C_LANES-1:0]      lane_vld, lane_last;
    logic [C_LANES*C_DATA_WIDTH-1:0] lane_data;

    assign feed.in_ready = ~reset & (state_q != DRAIN);
    assign accept        = feed.in_valid & feed.in_ready;
    assign last_accept   = accept & feed.in_last;
    assign at_max        = (beat_q == CW'(C_MAX_K));
    assign beat_inc      = at_max ? beat_q : beat_q + CW'(1);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        beat_d  = beat_q;
        beats_d = beats_q;
        ovf_d   = ovf_q;
        if (accept) begin
            beat_d = beat_inc;
            if (at_max) ovf_d = 1'b1;
        end
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    state_d = STREAM;
                    if (feed.in_last) begin
                        beat_d  = '0;
                        beats_d = beat_inc;
                        if (C_LANES > 1) begin
                            state_d = DRAIN;
                            drain_d = DW'(C_LANES - 1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DW'(1)) begin
                    state_d = IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            drain_q <= '0;
            beat_q  <= '0;
            beats_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            beat_q  <= beat_d;
            beats_q <= beats_d;
            ovf_q   <= ovf_d;
        end
    end

    // Lane 0 sees a zero bubble whenever nothing is accepted.
    for (genvar i = 0; i < C_LANES; i++) begin : g_lane
        gemm_skew_lane #(
            .LEN (i + 1),
            .W   (C_DATA_WIDTH)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .in_data   (accept ? feed.in_data[i*C_DATA_WIDTH +: C_DATA_WIDTH] : '0),
            .in_valid  (accept),
            .in_last   (last_accept),
            .out_data  (lane_data[i*C_DATA_WIDTH +: C_DATA_WIDTH]),
            .out_valid (lane_vld[i]),
            .out_last  (lane_last[i])
        );
    end

    // Masking with reset hides in-flight skew contents during the reset cycle itself.
    assign feed.out_data  = lane_data;
    assign feed.out_valid = lane_vld  & {C_LANES{~reset}};
    assign feed.out_last  = lane_last & {C_LANES{~reset}};
    assign tile_done      = lane_vld[C_LANES-1] & lane_last[C_LANES-1] & ~reset;
    assign tile_beats     = beats_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_gemm_skew_feeder.sv
// Directed bench for gemm_skew_feeder with a per-cycle behavioural model of skew and tiles.
module tb_gemm_skew_feeder;
    localparam int N    = 4;
    localparam int W    = 32;
    localparam int K    = 256;
    localparam int HMAX = 1024;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tile_done, overflow;
    logic [8:0] tile_beats;

    gemm_skew_feeder_if #(.C_DATA_WIDTH(W), .C_LANES(N)) sif ();

    gemm_skew_feeder #(
        .C_DATA_WIDTH (W),
        .C_LANES      (N),
        .C_MAX_K      (K)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .feed       (sif.slave),
        .tile_done  (tile_done),
        .tile_beats (tile_beats),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    // History of what the bench offered, indexed by cycle number.
    bit               acc_h  [HMAX];
    bit               last_h [HMAX];
    bit               rst_h  [HMAX];
    logic [N*W-1:0]   data_h [HMAX];

    int m_cnt   = 0;
    int m_beats = 0;
    bit m_ovf   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit clean(input int a, input int b);
        for (int j = a; j <= b; j++)
            if (rst_h[j]) return 1'b0;
        return 1'b1;
    endfunction

    // Ready is low for the N-1 cycles following a tile's last accept, unless a reset intervened.
    function automatic bit exp_ready(input int c);
        if (rst_h[c]) return 1'b0;
        for (int t = c - N + 1; t < c; t++)
            if (t >= 0)
                if (acc_h[t] && last_h[t] && clean(t, c)) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clock) begin : compare
        bit             rdy;
        logic [N-1:0]   ev, el;
        logic [W-1:0]   ed;
        int             t;
        if (!done && cyc < HMAX) begin
            rst_h[cyc]  = reset;
            last_h[cyc] = sif.in_last;
            data_h[cyc] = sif.in_data;
            rdy         = exp_ready(cyc);
            acc_h[cyc]  = sif.in_valid && rdy;
            chk("in_ready", {63'd0, sif.in_ready}, {63'd0, rdy});
            for (int i = 0; i < N; i++) begin
                t     = cyc - i - 1;
                ev[i] = 1'b0;
                el[i] = 1'b0;
                ed    = '0;
                if (t >= 0) begin
                    if (acc_h[t] && clean(t, cyc)) begin
                        ev[i] = 1'b1;
                        el[i] = last_h[t];
                        ed    = data_h[t][i*W +: W];
                    end
                end
                if (!reset) chk("lane_data", {32'd0, sif.out_data[i*W +: W]}, {32'd0, ed});
            end
            chk("out_valid", {60'd0, sif.out_valid}, {60'd0, ev});
            chk("out_last", {60'd0, sif.out_last}, {60'd0, el});
            chk("tile_done", {63'd0, tile_done}, {63'd0, el[N-1]});
            chk("tile_beats", {55'd0, tile_beats}, 64'(m_beats));
            chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
            if (reset) begin
                m_cnt   = 0;
                m_beats = 0;
                m_ovf   = 1'b0;
            end else if (acc_h[cyc]) begin
                if (m_cnt >= K) m_ovf = 1'b1;
                m_cnt = (m_cnt + 1 > K) ? K : m_cnt + 1;
                if (sif.in_last) begin
                    m_beats = m_cnt;
                    m_cnt   = 0;
                end
            end
            cyc++;
        end
    end

    function automatic logic [N*W-1:0] pat(input logic [31:0] base);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = base + 32'(i);
        return v;
    endfunction

    task automatic drive(input bit v, input logic [N*W-1:0] d, input bit l, input bit r);
        sif.in_valid = v;
        sif.in_data  = d;
        sif.in_last  = l;
        reset        = r;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        sif.in_last  = 1'b0;
        repeat (3) drive(1'b0, '0, 1'b0, 1'b1);
        chk("rst_tile_beats", {55'd0, tile_beats}, 64'd0);
        idle(2);

        // Single-beat tile.
        drive(1'b1, pat(32'h10), 1'b1, 1'b0);
        chk("t1_l0_vld", {60'd0, sif.out_valid}, 64'b0001);
        chk("t1_l0_dat", {32'd0, sif.out_data[31:0]}, 64'h10);
        chk("t1_rdy_low", {63'd0, sif.in_ready}, 64'd0);
        idle(3);
        chk("t1_l3_vld", {60'd0, sif.out_valid}, 64'b1000);
        chk("t1_l3_dat", {32'd0, sif.out_data[127:96]}, 64'h13);
        chk("t1_done", {63'd0, tile_done}, 64'd1);
        chk("t1_rdy_high", {63'd0, sif.in_ready}, 64'd1);
        chk("t1_beats", {55'd0, tile_beats}, 64'd1);
        idle(2);

        // Back-to-back three-beat tile.
        drive(1'b1, pat(32'h20), 1'b0, 1'b0);
        drive(1'b1, pat(32'h30), 1'b0, 1'b0);
        drive(1'b1, pat(32'h40), 1'b1, 1'b0);
        idle(3);
        chk("t2_done", {63'd0, tile_done}, 64'd1);
        chk("t2_last", {60'd0, sif.out_last}, 64'b1000);
        chk("t2_l3_dat", {32'd0, sif.out_data[127:96]}, 64'h43);
        chk("t2_beats", {55'd0, tile_beats}, 64'd3);
        idle(4);

        // Upstream stall between two beats.
        drive(1'b1, pat(32'h50), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t3_bubble_vld", {63'd0, sif.out_valid[0]}, 64'd0);
        chk("t3_bubble_dat", {32'd0, sif.out_data[31:0]}, 64'd0);
        drive(1'b1, pat(32'h60), 1'b1, 1'b0);
        chk("t3_l2_vld", {63'd0, sif.out_valid[2]}, 64'd1);
        chk("t3_l2_dat", {32'd0, sif.out_data[95:64]}, 64'h52);
        idle(5);

        // in_valid held high through the drain window.
        drive(1'b1, pat(32'h70), 1'b1, 1'b0);
        chk("t6_rdy_low", {63'd0, sif.in_ready}, 64'd0);
        repeat (3) drive(1'b1, pat(32'h80), 1'b1, 1'b0);
        chk("t6_rdy_high", {63'd0, sif.in_ready}, 64'd1);
        drive(1'b1, pat(32'h80), 1'b1, 1'b0);
        chk("t6_l0_vld", {63'd0, sif.out_valid[0]}, 64'd1);
        chk("t6_l0_dat", {32'd0, sif.out_data[31:0]}, 64'h80);
        idle(6);

        // Overflow: 257 beats, last on the final one.
        for (int b = 0; b < 257; b++)
            drive(1'b1, pat(32'h1000 + 32'(b * 8)), (b == 256), 1'b0);
        chk("t4_ovf", {63'd0, overflow}, 64'd1);
        chk("t4_beats", {55'd0, tile_beats}, 64'd256);
        idle(5);
        chk("t4_ovf_sticky", {63'd0, overflow}, 64'd1);

        // Reset in the middle of a five-beat tile.
        drive(1'b1, pat(32'h90), 1'b0, 1'b0);
        drive(1'b1, pat(32'h98), 1'b0, 1'b0);
        sif.in_valid = 1'b1;
        sif.in_data  = pat(32'hA0);
        sif.in_last  = 1'b0;
        reset        = 1'b1;
        #1;
        chk("t5_rst_vld", {60'd0, sif.out_valid}, 64'd0);
        chk("t5_rst_rdy", {63'd0, sif.in_ready}, 64'd0);
        @(posedge clock);
        #1;
        reset        = 1'b0;
        sif.in_valid = 1'b0;
        #1;
        chk("t5_rdy_after", {63'd0, sif.in_ready}, 64'd1);
        chk("t5_ovf_clr", {63'd0, overflow}, 64'd0);
        chk("t5_beats_clr", {55'd0, tile_beats}, 64'd0);
        idle(8);
        drive(1'b1, pat(32'hB0), 1'b1, 1'b0);
        idle(3);
        chk("t5_new_done", {63'd0, tile_done}, 64'd1);
        chk("t5_new_beats", {55'd0, tile_beats}, 64'd1);
        idle(2);

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
